// File: rtl/spw_rx_drain.sv
// ============================================================================
// Module   : spw_rx_drain
// Purpose  : Receive drain stage behind the SpaceWire codec RX FIFO. Pops
//            codec characters into a local 9-bit packet buffer, tracks
//            packet boundaries, last packet length and EEP count, and
//            offers a simple registered host read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spw_rx_drain #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     RX_EMPTY,
  input  logic [8:0]               DATA_O,
  output logic                     RD_DATA,
  input  logic                     CLEAR,
  input  logic                     HOST_RD,
  output logic [8:0]               HOST_DATA,
  output logic                     HOST_VALID,
  output logic                     HOST_EMPTY,
  output logic                     HOST_FULL,
  output logic [$clog2(DEPTH):0]   PKT_CNT,
  output logic [LEN_W-1:0]         LAST_LEN,
  output logic [7:0]               EEP_CNT
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_rd_data;
  logic [8:0]          r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_CW-1:0]     r_count;
  logic [c_CW-1:0]     r_pkt_cnt;
  logic [LEN_W-1:0]    r_run_len;
  logic [LEN_W-1:0]    r_last_len;
  logic [7:0]          r_eep_cnt;
  logic [8:0]          r_host_data;
  logic                r_host_valid;

  logic                w_wr;
  logic                w_rd;
  logic [8:0]          w_head;
  logic                w_wr_mark;
  logic                w_rd_mark;
  logic                w_is_eep;

  // CLEAR kills both the in-flight capture and any same-cycle host pop.
  assign w_wr      = (r_state == ST_CAPTURE) && !CLEAR;
  assign w_rd      = HOST_RD && (r_count != '0) && !CLEAR;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_wr_mark = w_wr && DATA_O[8];
  assign w_rd_mark = w_rd && w_head[8];
  // Any marker that is not a clean EOP counts as an error end.
  assign w_is_eep  = (DATA_O[7:0] != 8'h00);

  assign RD_DATA    = r_rd_data;
  assign HOST_DATA  = r_host_data;
  assign HOST_VALID = r_host_valid;
  assign HOST_EMPTY = (r_count == '0);
  assign HOST_FULL  = (r_count == c_CW'(DEPTH));
  assign PKT_CNT    = r_pkt_cnt;
  assign LAST_LEN   = r_last_len;
  assign EEP_CNT    = r_eep_cnt;

  // Drain FSM: full check happens in IDLE, so a pop always finds room.
  always_ff @(posedge CLOCK) begin
    if (RESET || CLEAR) begin
      r_state   <= ST_IDLE;
      r_rd_data <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!RX_EMPTY && !HOST_FULL) begin
            r_state   <= ST_READ;
            r_rd_data <= 1'b1;
          end
        end
        ST_READ: begin
          r_state   <= ST_CAPTURE;
          r_rd_data <= 1'b0;
        end
        ST_CAPTURE: begin
          r_state   <= ST_IDLE;
          r_rd_data <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rd_data <= 1'b0;
        end
      endcase
    end
  end

  // Character storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge CLOCK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= DATA_O;
    end
  end

  // Buffer pointers and occupancy; simultaneous write and pop cancel out.
  always_ff @(posedge CLOCK) begin
    if (RESET || CLEAR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered host read port: data and a one-cycle valid pulse.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_host_data  <= '0;
      r_host_valid <= 1'b0;
    end else begin
      r_host_valid <= w_rd;
      if (w_rd) r_host_data <= w_head;
    end
  end

  // Packet bookkeeping: running length, last length, packet and EEP counts.
  always_ff @(posedge CLOCK) begin
    if (RESET || CLEAR) begin
      r_pkt_cnt  <= '0;
      r_run_len  <= '0;
      r_last_len <= '0;
      r_eep_cnt  <= '0;
    end else begin
      unique case ({w_wr_mark, w_rd_mark})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + c_CW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - c_CW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      if (w_wr) begin
        if (DATA_O[8]) begin
          r_last_len <= r_run_len;
          r_run_len  <= '0;
          if (w_is_eep && (r_eep_cnt != 8'hFF)) r_eep_cnt <= r_eep_cnt + 8'd1;
        end else if (r_run_len != '1) begin
          r_run_len <= r_run_len + LEN_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spw_rx_drain.sv
// ============================================================================
// Module   : tb_spw_rx_drain
// Purpose  : Self-checking bench for spw_rx_drain with a queue-based codec
//            model and a packet-level reference model of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spw_rx_drain;

  localparam int DEPTH = 64;
  localparam int LEN_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              CLOCK = 1'b0;
  logic              RESET, RX_EMPTY, CLEAR, HOST_RD;
  logic [8:0]        DATA_O;
  logic              RD_DATA, HOST_VALID, HOST_EMPTY, HOST_FULL;
  logic [8:0]        HOST_DATA;
  logic [CW-1:0]     PKT_CNT;
  logic [LEN_W-1:0]  LAST_LEN;
  logic [7:0]        EEP_CNT;

  spw_rx_drain #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RX_EMPTY(RX_EMPTY), .DATA_O(DATA_O),
    .RD_DATA(RD_DATA), .CLEAR(CLEAR), .HOST_RD(HOST_RD),
    .HOST_DATA(HOST_DATA), .HOST_VALID(HOST_VALID), .HOST_EMPTY(HOST_EMPTY),
    .HOST_FULL(HOST_FULL), .PKT_CNT(PKT_CNT), .LAST_LEN(LAST_LEN),
    .EEP_CNT(EEP_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Codec FIFO model and reference state.
  logic [8:0] cq[$];
  logic [8:0] mbuf[$];
  int         m_run, m_last, m_eep;
  logic [8:0] exp_rd[$], got_rd[$];
  int         ll_obs[$];
  int         rd_count, underflow, cyc;
  int         rd_times[$];
  bit         in_cap;
  logic [8:0] inflight;

  function automatic int mpkt();
    int n = 0;
    foreach (mbuf[i]) if (mbuf[i][8]) n++;
    return n;
  endfunction

  function automatic logic [8:0] rand_char();
    int r = $urandom_range(0, 9);
    if (r == 0) return 9'h100;
    if (r == 1) return 9'h101;
    if (r == 2) return {1'b1, 8'($urandom)};
    return {1'b0, 8'($urandom)};
  endfunction

  task automatic model_rx(input logic [8:0] c);
    if (c[8]) begin
      m_last = m_run;
      m_run  = 0;
      if (c[7:0] != 8'h00 && m_eep < 255) m_eep++;
    end else if (m_run < (1 << LEN_W) - 1) begin
      m_run++;
    end
    mbuf.push_back(c);
  endtask

  task automatic model_clear();
    mbuf.delete();
    m_run = 0; m_last = 0; m_eep = 0;
  endtask

  task automatic push(input logic [8:0] c);
    cq.push_back(c);
    RX_EMPTY = 1'b0;
  endtask

  // One clock: advance the reference model using the inputs of the cycle
  // that just ended, then play the codec side of the read handshake.
  task automatic step();
    logic clr_was, hrd_was, rd_was, cap_was;
    logic [8:0] popped;
    clr_was = CLEAR; hrd_was = HOST_RD; rd_was = RD_DATA; cap_was = in_cap;
    @(posedge CLOCK); #1;
    cyc++;
    if (clr_was) begin
      model_clear();
    end else begin
      if (hrd_was && mbuf.size() > 0) begin
        popped = mbuf.pop_front();
        exp_rd.push_back(popped);
      end
      if (cap_was) begin
        model_rx(inflight);
        if (inflight[8]) ll_obs.push_back(int'(LAST_LEN));
      end
    end
    in_cap = rd_was && !clr_was;
    if (HOST_VALID) got_rd.push_back(HOST_DATA);
    if (RD_DATA) begin
      rd_count++;
      rd_times.push_back(cyc);
      if (cq.size() > 0) begin
        inflight = cq.pop_front();
        DATA_O   = inflight;
      end else begin
        underflow++;
        inflight = 9'h1FF;
      end
    end
    RX_EMPTY = (cq.size() == 0);
  endtask

  task automatic apply_reset();
    RESET = 1'b1; CLEAR = 1'b0; HOST_RD = 1'b0;
    cq.delete(); RX_EMPTY = 1'b1; DATA_O = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    model_clear();
    in_cap = 1'b0;
    exp_rd.delete(); got_rd.delete(); ll_obs.delete(); rd_times.delete();
    rd_count = 0;
  endtask

  task automatic wait_idle(input int bound, output bit to);
    int n = 0;
    while ((cq.size() > 0 || in_cap || RD_DATA) && n < bound) begin
      step(); n++;
    end
    to = (n >= bound);
  endtask

  task automatic drain_all(input int bound, output bit to);
    int n = 0;
    while ((mbuf.size() > 0 || cq.size() > 0 || in_cap || RD_DATA) && n < bound) begin
      HOST_RD = 1'b1; step(); n++;
    end
    HOST_RD = 1'b0;
    to = (n >= bound);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({RD_DATA, HOST_DATA, HOST_VALID, HOST_EMPTY, HOST_FULL, PKT_CNT, LAST_LEN, EEP_CNT} !==
        {1'b0, 9'h000, 1'b0, 1'b1, 1'b0, CW'(0), LEN_W'(0), 8'h00}) begin
      errors++;
      $display("FAIL reset_values got rd=%b hd=%h hv=%b he=%b hf=%b pkt=%0d len=%0d eep=%0d",
               RD_DATA, HOST_DATA, HOST_VALID, HOST_EMPTY, HOST_FULL, PKT_CNT, LAST_LEN, EEP_CNT);
    end
    // Reset while a character is in flight: it must be lost.
    push(9'h055);
    step();
    apply_reset();
    repeat (4) step();
    checks++;
    if (HOST_EMPTY !== 1'b1 || RD_DATA !== 1'b0 || HOST_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_midflight he=%b rd=%b hv=%b required 1 0 0", HOST_EMPTY, RD_DATA, HOST_VALID);
    end
  endtask

  task automatic test_packet();
    logic [8:0] pkt[6] = '{9'h011, 9'h012, 9'h013, 9'h014, 9'h015, 9'h100};
    bit to, bad;
    apply_reset();
    foreach (pkt[i]) push(pkt[i]);
    step();
    checks++;
    if (RD_DATA !== 1'b1) begin errors++; $display("FAIL pop_latency rd=%b required 1", RD_DATA); end
    step();
    checks++;
    if (HOST_EMPTY !== 1'b1) begin errors++; $display("FAIL early_write he=%b required 1", HOST_EMPTY); end
    step();
    checks++;
    if (HOST_EMPTY !== 1'b0) begin errors++; $display("FAIL write_latency he=%b required 0", HOST_EMPTY); end
    wait_idle(60, to);
    checks++;
    if (to) begin errors++; $display("FAIL packet_timeout"); end
    checks++;
    if (rd_count != 6) begin errors++; $display("FAIL packet_pops got %0d required 6", rd_count); end
    bad = 0;
    for (int i = 1; i < rd_times.size(); i++) if (rd_times[i] - rd_times[i-1] != 3) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL pop_spacing not 3 cycles apart"); end
    checks++;
    if (PKT_CNT !== CW'(1) || LAST_LEN !== LEN_W'(5) || EEP_CNT !== 8'd0) begin
      errors++;
      $display("FAIL packet_counters pkt=%0d len=%0d eep=%0d required 1 5 0", PKT_CNT, LAST_LEN, EEP_CNT);
    end
    for (int i = 0; i < 6; i++) begin HOST_RD = 1'b1; step(); end
    HOST_RD = 1'b0;
    checks++;
    if (got_rd.size() != 6) begin
      errors++; $display("FAIL packet_reads got %0d required 6", got_rd.size());
    end else begin
      foreach (pkt[i]) if (got_rd[i] !== pkt[i]) begin
        errors++; $display("FAIL packet_data[%0d] got %h required %h", i, got_rd[i], pkt[i]);
      end
    end
    checks++;
    if (PKT_CNT !== CW'(0)) begin errors++; $display("FAIL packet_pkt_after got %0d required 0", PKT_CNT); end
  endtask

  task automatic test_eep();
    logic [8:0] src[5] = '{9'h021, 9'h022, 9'h023, 9'h101, 9'h100};
    bit to;
    apply_reset();
    foreach (src[i]) push(src[i]);
    wait_idle(60, to);
    checks++;
    if (to) begin errors++; $display("FAIL eep_timeout"); end
    checks++;
    if (ll_obs.size() != 2 || ll_obs[0] != 3 || ll_obs[1] != 0) begin
      errors++; $display("FAIL eep_lastlen_seq n=%0d required 3 then 0", ll_obs.size());
    end
    checks++;
    if (LAST_LEN !== LEN_W'(0) || EEP_CNT !== 8'd1 || PKT_CNT !== CW'(2)) begin
      errors++;
      $display("FAIL eep_counters len=%0d eep=%0d pkt=%0d required 0 1 2", LAST_LEN, EEP_CNT, PKT_CNT);
    end
    drain_all(40, to);
    checks++;
    if (got_rd.size() != 5) begin
      errors++; $display("FAIL eep_reads got %0d required 5", got_rd.size());
    end else begin
      foreach (src[i]) if (got_rd[i] !== src[i]) begin
        errors++; $display("FAIL eep_data[%0d] got %h required %h", i, got_rd[i], src[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [8:0] src[$];
    bit to;
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      src.push_back(rand_char());
      push(src[i]);
    end
    repeat (230) step();
    checks++;
    if (rd_count != DEPTH || HOST_FULL !== 1'b1 || cq.size() != 6) begin
      errors++;
      $display("FAIL fill pops=%0d full=%b left=%0d required %0d 1 6", rd_count, HOST_FULL, cq.size(), DEPTH);
    end
    checks++;
    if (PKT_CNT !== CW'(mpkt())) begin
      errors++; $display("FAIL fill_pkt got %0d required %0d", PKT_CNT, mpkt());
    end
    HOST_RD = 1'b1; step(); HOST_RD = 1'b0;
    checks++;
    if (HOST_FULL !== 1'b0) begin errors++; $display("FAIL full_after_pop got %b required 0", HOST_FULL); end
    repeat (30) step();
    checks++;
    if (rd_count != DEPTH + 1 || HOST_FULL !== 1'b1) begin
      errors++; $display("FAIL refill pops=%0d full=%b required %0d 1", rd_count, HOST_FULL, DEPTH + 1);
    end
    drain_all(600, to);
    checks++;
    if (to || got_rd.size() != 70) begin
      errors++; $display("FAIL full_reads got %0d required 70 timeout=%b", got_rd.size(), to);
    end else begin
      foreach (src[i]) if (got_rd[i] !== src[i]) begin
        errors++; $display("FAIL full_order[%0d] got %h required %h", i, got_rd[i], src[i]);
      end
    end
  endtask

  task automatic test_empty_read();
    logic [8:0] src[$];
    bit to;
    apply_reset();
    HOST_RD = 1'b1; step(); HOST_RD = 1'b0;
    checks++;
    if (HOST_VALID !== 1'b0 || HOST_EMPTY !== 1'b1 || PKT_CNT !== CW'(0) || got_rd.size() != 0) begin
      errors++; $display("FAIL empty_read hv=%b he=%b pkt=%0d required 0 1 0", HOST_VALID, HOST_EMPTY, PKT_CNT);
    end
    for (int i = 0; i < 8; i++) begin
      src.push_back(rand_char());
      push(src[i]);
    end
    drain_all(80, to);
    checks++;
    if (to || got_rd.size() != 8) begin
      errors++; $display("FAIL stream_reads got %0d required 8 timeout=%b", got_rd.size(), to);
    end else begin
      foreach (src[i]) if (got_rd[i] !== src[i]) begin
        errors++; $display("FAIL stream_order[%0d] got %h required %h", i, got_rd[i], src[i]);
      end
    end
  endtask

  task automatic test_marker_same_cycle();
    bit to;
    int n = 0;
    apply_reset();
    push(9'h100);
    wait_idle(20, to);
    checks++;
    if (to || PKT_CNT !== CW'(1)) begin
      errors++; $display("FAIL same_setup pkt=%0d required 1", PKT_CNT);
    end
    push(9'h100);
    while (!in_cap && n < 10) begin step(); n++; end
    checks++;
    if (!in_cap) begin errors++; $display("FAIL same_capture_timeout"); end
    HOST_RD = 1'b1; step(); HOST_RD = 1'b0;
    checks++;
    if (PKT_CNT !== CW'(1) || HOST_VALID !== 1'b1 || HOST_DATA !== 9'h100 || HOST_EMPTY !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle pkt=%0d hv=%b hd=%h he=%b required 1 1 100 0", PKT_CNT, HOST_VALID, HOST_DATA, HOST_EMPTY);
    end
  endtask

  task automatic test_clear();
    logic [8:0] src[12];
    bit to;
    int n = 0;
    apply_reset();
    foreach (src[i]) src[i] = {1'b0, 8'($urandom)};
    src[3] = 9'h101;
    src[7] = 9'h100;
    foreach (src[i]) push(src[i]);
    while (!(mbuf.size() == 10 && in_cap) && n < 60) begin step(); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL clear_setup_timeout"); end
    CLEAR = 1'b1; HOST_RD = 1'b1; step(); CLEAR = 1'b0; HOST_RD = 1'b0;
    checks++;
    if (HOST_EMPTY !== 1'b1 || PKT_CNT !== CW'(0) || LAST_LEN !== LEN_W'(0) ||
        EEP_CNT !== 8'd0 || HOST_VALID !== 1'b0) begin
      errors++;
      $display("FAIL clear_state he=%b pkt=%0d len=%0d eep=%0d hv=%b required 1 0 0 0 0",
               HOST_EMPTY, PKT_CNT, LAST_LEN, EEP_CNT, HOST_VALID);
    end
    wait_idle(30, to);
    drain_all(30, to);
    checks++;
    if (got_rd.size() != 1 || got_rd[0] !== src[11]) begin
      errors++; $display("FAIL clear_next n=%0d required 1 char %h", got_rd.size(), src[11]);
    end
  endtask

  task automatic test_random();
    bit to;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) push(rand_char());
      HOST_RD = ($urandom_range(0, 2) == 0);
      CLEAR   = ($urandom_range(0, 79) == 0);
      step();
      CLEAR = 1'b0;
      checks++;
      if (HOST_EMPTY !== (mbuf.size() == 0) || HOST_FULL !== (mbuf.size() == DEPTH)) begin
        errors++; $display("FAIL rand_occ cyc=%0d he=%b hf=%b model=%0d", cyc, HOST_EMPTY, HOST_FULL, mbuf.size());
      end
      checks++;
      if (PKT_CNT !== CW'(mpkt()) || LAST_LEN !== LEN_W'(m_last) || EEP_CNT !== 8'(m_eep)) begin
        errors++;
        $display("FAIL rand_cnt cyc=%0d pkt=%0d/%0d len=%0d/%0d eep=%0d/%0d (got/required)",
                 cyc, PKT_CNT, mpkt(), LAST_LEN, m_last, EEP_CNT, m_eep);
      end
    end
    HOST_RD = 1'b0;
    drain_all(400, to);
    checks++;
    if (to || got_rd.size() != exp_rd.size()) begin
      errors++; $display("FAIL rand_reads got %0d required %0d", got_rd.size(), exp_rd.size());
    end else begin
      foreach (exp_rd[i]) if (got_rd[i] !== exp_rd[i]) begin
        errors++; $display("FAIL rand_data[%0d] got %h required %h", i, got_rd[i], exp_rd[i]);
      end
    end
    checks++;
    if (underflow != 0) begin errors++; $display("FAIL codec_underflow got %0d required 0", underflow); end
  endtask

  initial begin
    RESET = 1'b1; CLEAR = 1'b0; HOST_RD = 1'b0; RX_EMPTY = 1'b1; DATA_O = '0;
    in_cap = 1'b0; inflight = '0; rd_count = 0; underflow = 0; cyc = 0;
    m_run = 0; m_last = 0; m_eep = 0;
    test_reset();
    test_packet();
    test_eep();
    test_full();
    test_empty_read();
    test_marker_same_cycle();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/spw_rx_drain.md
# spw_rx_drain

Receive-side drain stage placed directly downstream of the SpaceWire codec top (SPW_TOP) receive FIFO port. It pops received characters (DATA_O / RD_DATA / RX_EMPTY), stores them in a local 9-bit packet buffer, and tracks packet boundaries, lengths and error-end markers. The host (PIO / bus bridge) reads complete characters from its own read port without seeing the codec's read handshake.

## Interface
Parameters:
- DEPTH, 64, buffer depth in characters; power of two, at least 4.
- LEN_W, 16, width of the packet-length counter.

Ports:
- CLOCK  in  1  single clock for all logic, the same clock as SPW_TOP.
- RESET  in  1  synchronous, active-high reset.
- RX_EMPTY  in  1  codec receive FIFO is empty.
- DATA_O  in  9  codec receive character. Bit 8 set means a marker: bits [7:0] = 0x00 is EOP, 0x01 is EEP.
- RD_DATA  out  1  one-cycle pop strobe to the codec.
- CLEAR  in  1  synchronous flush of buffer and counters.
- HOST_RD  in  1  pop one character from the buffer.
- HOST_DATA  out  9  popped character, registered.
- HOST_VALID  out  1  HOST_DATA is valid this cycle (one-cycle pulse).
- HOST_EMPTY  out  1  buffer holds no characters.
- HOST_FULL  out  1  buffer holds DEPTH characters.
- PKT_CNT  out  $clog2(DEPTH)+1  number of complete packets (markers) currently in the buffer.
- LAST_LEN  out  LEN_W  data-character count of the most recently received packet.
- EEP_CNT  out  8  number of EEP-terminated packets received; saturates at 255.

## Operation
- Drain FSM has three states: IDLE, READ, CAPTURE.
  - IDLE → READ when RX_EMPTY=0, HOST_FULL=0 and CLEAR=0.
  - READ lasts one cycle with RD_DATA=1, then always → CAPTURE.
  - CAPTURE writes DATA_O into the buffer, then always → IDLE.
- RD_DATA is high only in READ. At most one codec pop is issued every 3 cycles.
- The full check happens before the pop and only the host removes entries, so a pop never finds the buffer full. The buffer never overflows and never drops characters.
- Each CAPTURE of a data character (bit 8 = 0) increments the running length. The running length saturates at 2^LEN_W−1.
- Each CAPTURE of a marker (bit 8 = 1):
  - LAST_LEN ← running length, and the running length resets to 0.
  - PKT_CNT increments.
  - If the marker is EEP, EEP_CNT increments (saturating).
  - A marker with bits [7:0] other than 0x00 or 0x01 is treated as EEP.
- Markers are stored in the buffer as-is, so the host sees the boundary in the stream.
- Host read:
  - HOST_RD with HOST_EMPTY=0 pops the head. HOST_DATA and HOST_VALID appear the next cycle.
  - HOST_RD while empty is ignored (no pulse, no state change).
  - Popping a marker decrements PKT_CNT.
- Same-cycle write and pop: the occupancy count is unchanged and both take effect.
  - If a marker is written and a marker is popped in the same cycle, PKT_CNT is unchanged.
- CLEAR:
  - Empties the buffer and zeroes PKT_CNT, LAST_LEN, EEP_CNT and the running length.
  - Forces the FSM to IDLE. A character fetched in the READ/CAPTURE in progress is discarded.
  - A HOST_RD in the same cycle is ignored.
  - CLEAR has priority over everything except RESET.

## Timing
- Reset values: RD_DATA=0, HOST_DATA=0, HOST_VALID=0, HOST_EMPTY=1, HOST_FULL=0, PKT_CNT=0, LAST_LEN=0, EEP_CNT=0. FSM is in IDLE.
- Codec contract: DATA_O is valid in the cycle after RD_DATA. It is sampled in CAPTURE.
- Latency, RX_EMPTY falling to buffer write: RX_EMPTY low in cycle n → RD_DATA in n+1 → captured at the end of n+2 → HOST_EMPTY low in n+3.
- Throughput: one character per 3 cycles (66 Mchar/s at 200 MHz), which is well above the link rate.
- HOST_RD in cycle n → HOST_DATA/HOST_VALID in n+1. HOST_EMPTY, HOST_FULL and PKT_CNT update at the end of cycle n.
- LAST_LEN, PKT_CNT and EEP_CNT are visible the cycle after the marker's CAPTURE.
- RESET mid-READ or mid-CAPTURE: the character in flight is lost and all outputs return to their reset values.

## Test plan
- After reset, present a 5-byte packet 0x11..0x15 + EOP (0x100) in the codec model → RD_DATA pulses exactly 6 times, each 3 cycles apart. Then PKT_CNT=1, LAST_LEN=5, EEP_CNT=0, and host reads return 0x011,0x012,0x013,0x014,0x015,0x100. PKT_CNT=0 after the last pop.
- 3 data bytes + EEP (0x101), then 0 bytes + EOP → LAST_LEN=3 then 0, EEP_CNT=1, PKT_CNT=2.
- DEPTH=64, host idle, 70 characters queued in the codec → exactly 64 RD_DATA pulses and HOST_FULL=1. After one HOST_RD, exactly one more pop occurs. No character is lost or reordered.
- HOST_RD on an empty buffer → no HOST_VALID and no state change. HOST_RD held high while characters stream in → one HOST_VALID per stored character, and HOST_DATA matches the input order.
- Marker written and marker popped in the same cycle with PKT_CNT=1 → PKT_CNT stays 1.
- CLEAR asserted in the CAPTURE cycle with 10 characters buffered → next cycle HOST_EMPTY=1, all counters 0, and the in-flight character is absent. The next codec character is stored normally.
